// File: rtl/satd_ctrl_diff_if.sv
// satd_ctrl_diff_if
// Groups the pixel inputs and the sequencer/residual outputs of satd_ctrl_diff.
//   org, cur    : 8-bit unsigned pixels (original, current/predicted)
//   out_signal  : 10-bit decoded control vector
//   state       : 2-bit phase (0 IDLE, 1 DIFF, 2 HAD, 3 ACC)
//   count       : 3-bit cycle index within the phase
//   diff        : 8-bit registered saturated residual, two's complement
// master drives the pixels and observes the outputs; slave is the design side.
interface satd_ctrl_diff_if;
  logic [7:0] org;
  logic [7:0] cur;
  logic [9:0] out_signal;
  logic [1:0] state;
  logic [2:0] count;
  logic [7:0] diff;

  modport master (
    output org,
    output cur,
    input  out_signal,
    input  state,
    input  count,
    input  diff
  );

  modport slave (
    input  org,
    input  cur,
    output out_signal,
    output state,
    output count,
    output diff
  );
endinterface

// File: rtl/satd_ctrl_diff.sv
// satd_ctrl_diff
// Front-end sequencer and residual unit of the SATD datapath. A free-running
// frame FSM walks DIFF -> HAD -> ACC (8 cycles each, 24-cycle period) after
// leaving IDLE, and decodes enables/strobes onto out_signal. During DIFF the
// residual org - cur is registered, saturated to the signed 8-bit range.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, priority over all other logic
//   bus : satd_ctrl_diff_if.slave (org, cur in; out_signal, state, count, diff out)
module satd_ctrl_diff (
  input  logic             clk,
  input  logic             rst,
  satd_ctrl_diff_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIFF = 2'd1,
    ST_HAD  = 2'd2,
    ST_ACC  = 2'd3
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] count_r;
  logic [2:0] next_count_s;
  logic [7:0] diff_r;
  logic [9:0] out_signal_s;
  logic       diff_en_s;

  // Widen both pixels with a zero MSB so the 9-bit difference is exact
  // (-255..+255), then clamp into [-128, +127]. Bits [8:7] disagreeing
  // means the value left the 8-bit signed range.
  function automatic logic [7:0] sat8_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    logic [7:0] r;
    d = {1'b0, a} - {1'b0, b};
    case (d[8:7])
      2'b01:   r = 8'h7F;
      2'b10:   r = 8'h80;
      default: r = d[7:0];
    endcase
    return r;
  endfunction

  // Phase/count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= 3'd0;
    end else begin
      state_r <= next_state_s;
      count_r <= next_count_s;
    end
  end

  // Next-state logic: IDLE leaves unconditionally; phases advance on count wrap.
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r + 3'd1;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_DIFF;
        next_count_s = 3'd0;
      end
      ST_DIFF: begin
        if (count_r == 3'd7) begin
          next_state_s = ST_HAD;
        end else begin
          next_state_s = ST_DIFF;
        end
      end
      ST_HAD: begin
        if (count_r == 3'd7) begin
          next_state_s = ST_ACC;
        end else begin
          next_state_s = ST_HAD;
        end
      end
      ST_ACC: begin
        if (count_r == 3'd7) begin
          next_state_s = ST_DIFF;
        end else begin
          next_state_s = ST_ACC;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_count_s = 3'd0;
      end
    endcase
  end

  // Control vector decode from the current phase and count.
  always_comb begin
    out_signal_s      = 10'd0;
    out_signal_s[0]   = (state_r == ST_DIFF);
    out_signal_s[1]   = (state_r == ST_HAD);
    out_signal_s[2]   = (state_r == ST_ACC);
    out_signal_s[3]   = (state_r != ST_IDLE) && (count_r == 3'd0);
    out_signal_s[4]   = (state_r != ST_IDLE) && (count_r == 3'd7);
    out_signal_s[5]   = (state_r == ST_IDLE);
    out_signal_s[6]   = (state_r == ST_ACC) && (count_r == 3'd7);
    out_signal_s[7]   = (state_r != ST_IDLE) && (count_r[2] == 1'b0);
    out_signal_s[8]   = (state_r == ST_DIFF) && (count_r == 3'd0);
    out_signal_s[9]   = 1'b0;
  end

  assign diff_en_s = out_signal_s[0];

  // Residual register: samples only while in DIFF, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r <= 8'h00;
    end else if (diff_en_s) begin
      diff_r <= sat8_sub(bus.org, bus.cur);
    end else begin
      diff_r <= diff_r;
    end
  end

  assign bus.out_signal = out_signal_s;
  assign bus.state      = state_r;
  assign bus.count      = count_r;
  assign bus.diff       = diff_r;

endmodule

// File: tb/tb_satd_ctrl_diff.sv
module tb_satd_ctrl_diff;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  satd_ctrl_diff_if bus ();

  satd_ctrl_diff dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First-frame DIFF vectors, one per DIFF cycle, with hand-computed residuals.
  logic [7:0] org_tab [8] = '{8'd100, 8'd90,  8'd200, 8'd50,  8'd255, 8'd0,   8'd127, 8'd0};
  logic [7:0] cur_tab [8] = '{8'd90,  8'd100, 8'd50,  8'd200, 8'd128, 8'd128, 8'd0,   8'd255};
  logic [7:0] exp_tab [8] = '{8'h0A,  8'hF6,  8'h7F,  8'h80,  8'h7F,  8'h80,  8'h7F,  8'h80};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] exp_diff;
    int         idx;
    int         pidx;
    int         pstate;
    int         estate;
    int         ecount;

    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.org  = 8'd0;
    bus.cur  = 8'd0;
    exp_diff = 8'h00;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_state", {14'd0, bus.state}, 16'd0);
    check("rst_count", {13'd0, bus.count}, 16'd0);
    check("rst_out",   {6'd0, bus.out_signal}, 16'h020);
    check("rst_diff",  {8'd0, bus.diff}, 16'h00);

    // First edge out of reset.
    rst = 1'b0;
    tick();
    check("edge1_state", {14'd0, bus.state}, 16'd1);
    check("edge1_count", {13'd0, bus.count}, 16'd0);
    check("edge1_out",   {6'd0, bus.out_signal}, 16'h189);

    // Edges 2..50: state index idx = n-1 after edge n; inputs chosen from the
    // phase before the edge.
    for (int n = 2; n <= 50; n++) begin
      pidx   = n - 2;
      pstate = (pidx / 8) % 3 + 1;
      if (pstate == 1 && pidx < 8) begin
        bus.org  = org_tab[pidx % 8];
        bus.cur  = cur_tab[pidx % 8];
        exp_diff = exp_tab[pidx % 8];
      end else if (pstate == 1) begin
        bus.org  = 8'd255;
        bus.cur  = 8'd0;
        exp_diff = 8'h7F;
      end else begin
        // HAD/ACC: a value that would change diff if it were sampled.
        bus.org  = 8'd255;
        bus.cur  = 8'd0;
      end
      tick();
      idx    = n - 1;
      estate = (idx / 8) % 3 + 1;
      ecount = idx % 8;
      check($sformatf("seq_state_e%0d", n), {14'd0, bus.state}, 16'(estate));
      check($sformatf("seq_count_e%0d", n), {13'd0, bus.count}, 16'(ecount));
      check($sformatf("diff_e%0d", n), {8'd0, bus.diff}, {8'd0, exp_diff});
      check($sformatf("frame_start_e%0d", n), {15'd0, bus.out_signal[8]},
            ((idx % 24) == 0) ? 16'd1 : 16'd0);
      if (estate == 1 && ecount == 7)
        check("out_diff7", {6'd0, bus.out_signal}, 16'h011);
      if (estate == 2 && ecount == 0)
        check("out_had0", {6'd0, bus.out_signal}, 16'h08A);
      if (estate == 3 && ecount == 7)
        check("out_acc7", {6'd0, bus.out_signal}, 16'h054);
      if (estate == 3 && ecount == 3)
        check("out_acc3", {6'd0, bus.out_signal}, 16'h084);
    end

    // Run on to HAD count 5 (idx 61, edge 62).
    bus.org = 8'd10;
    bus.cur = 8'd3;
    for (int n = 51; n <= 62; n++) tick();
    check("pre_rst_state", {14'd0, bus.state}, 16'd2);
    check("pre_rst_count", {13'd0, bus.count}, 16'd5);
    check("pre_rst_diff",  {8'd0, bus.diff}, 16'h07);

    // One-cycle mid-frame reset.
    rst = 1'b1;
    tick();
    check("mid_rst_state", {14'd0, bus.state}, 16'd0);
    check("mid_rst_count", {13'd0, bus.count}, 16'd0);
    check("mid_rst_diff",  {8'd0, bus.diff}, 16'h00);
    check("mid_rst_out",   {6'd0, bus.out_signal}, 16'h020);
    rst = 1'b0;
    tick();
    check("post_rst_state", {14'd0, bus.state}, 16'd1);
    check("post_rst_count", {13'd0, bus.count}, 16'd0);
    check("post_rst_diff",  {8'd0, bus.diff}, 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
